// File: rtl/serial_fifo_pkg.sv
// Shared types and default parameters for the serial-input FIFO.
package serial_fifo_pkg;

    // Order in which serial bits are assembled into a word.
    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    // Deserializer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } deser_state_e;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_BIT_CYCLES = 15;
    localparam bit_order_e  DEF_BIT_ORDER  = MSB_FIRST;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrap-around pointers and a registered
// count/full/empty view that already includes this cycle's push and pop.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_pop_ok,
    output logic                         o_push_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_pop_ok;
    logic              w_push_ok;
    logic [CNT_W-1:0]  w_count_next;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_pop_ok    = i_pop & ~r_empty;
    assign w_push_ok   = i_push & (~r_full | w_pop_ok);
    assign o_pop_ok    = w_pop_ok;
    assign o_push_drop = i_push & ~w_push_ok;
    assign o_head      = r_mem[r_rptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage write; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

endmodule

// File: rtl/serial_fifo_n.sv
// Serial-frame deserializer feeding a FIFO, with edge-triggered dequeue,
// sticky overflow and one-cycle underflow / frame-error pulses.
module serial_fifo_n
    import serial_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
    parameter bit_order_e  BIT_ORDER  = DEF_BIT_ORDER
) (
    input  logic                        clock1M,
    input  logic                        reset,
    input  logic                        data_in,
    input  logic                        write_in,
    input  logic                        dequeue_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        status_out,
    output logic                        empty_out,
    output logic [$clog2(DEPTH+1)-1:0]  count_out,
    output logic                        overflow_out,
    output logic                        underflow_out,
    output logic                        frame_err_out
);

    localparam int unsigned BC_W = $clog2(BIT_CYCLES);
    localparam int unsigned NB_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] SAMPLE_AT = BC_W'(BIT_CYCLES / 2);
    localparam logic [BC_W-1:0] LAST_CNT  = BC_W'(BIT_CYCLES - 1);
    localparam logic [NB_W-1:0] LAST_BIT  = NB_W'(DATA_W - 1);

    deser_state_e      r_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [NB_W-1:0]   r_nbits;
    logic [DATA_W-1:0] r_shift;
    logic              r_armed;
    logic              r_frame_err;

    logic              r_deq_q;
    logic              r_deq_prev;
    logic [DATA_W-1:0] r_data_out;
    logic              r_overflow;
    logic              r_underflow;

    logic [DATA_W-1:0] w_shift_next;
    logic              w_push;
    logic              w_pop;
    logic              w_pop_ok;
    logic              w_push_drop;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [$clog2(DEPTH+1)-1:0] w_count;

    assign w_push = (r_state == PUSH);
    assign w_pop  = r_deq_q & ~r_deq_prev;

    // Shift register input, placed according to the configured bit order.
    always_comb begin
        w_shift_next = r_shift;
        if (BIT_ORDER == MSB_FIRST) begin
            w_shift_next = {r_shift[DATA_W-2:0], data_in};
        end else begin
            w_shift_next = {data_in, r_shift[DATA_W-1:1]};
        end
    end

    // Deserializer: waits for a fresh frame, samples mid-bit, hands the word to the FIFO.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_nbits     <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // r_armed records that write_in was low since the last word,
                    // so a frame still held high after PUSH cannot restart.
                    if (!write_in) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_nbits   <= '0;
                    end
                end
                SHIFT: begin
                    if (!write_in) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                        r_armed     <= 1'b1;
                    end else begin
                        r_bit_cnt <= (r_bit_cnt == LAST_CNT) ? '0 : r_bit_cnt + BC_W'(1);
                        if (r_bit_cnt == SAMPLE_AT) begin
                            r_shift <= w_shift_next;
                            r_nbits <= r_nbits + NB_W'(1);
                            if (r_nbits == LAST_BIT) begin
                                r_state <= PUSH;
                            end
                        end
                    end
                end
                PUSH: begin
                    r_state <= IDLE;
                    r_armed <= ~write_in;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Dequeue request registered once, then rising-edge detected into a single pop.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_deq_q    <= 1'b0;
            r_deq_prev <= 1'b0;
        end else begin
            r_deq_q    <= dequeue_in;
            r_deq_prev <= r_deq_q;
        end
    end

    // Output word, sticky overflow and underflow pulse.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop_ok)    r_data_out <= w_head;
            if (w_push_drop) r_overflow <= 1'b1;
            r_underflow <= w_pop & ~w_pop_ok;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (clock1M),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_pop_ok    (w_pop_ok),
        .o_push_drop (w_push_drop)
    );

    assign data_out      = r_data_out;
    assign status_out    = w_full;
    assign empty_out     = w_empty;
    assign count_out     = w_count;
    assign overflow_out  = r_overflow;
    assign underflow_out = r_underflow;
    assign frame_err_out = r_frame_err;

endmodule

// File: tb/tb_serial_fifo_n.sv
// Directed bench for serial_fifo_n with a word scoreboard.
module tb_serial_fifo_n;

    localparam int BC = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in, write_in, dequeue_in;
    logic [7:0] data_out;
    logic       status_out, empty_out, overflow_out, underflow_out, frame_err_out;
    logic [3:0] count_out;

    logic        din16, wr16, deq16;
    logic [15:0] dout16;
    logic        full16, empty16, ovf16, unf16, ferr16;
    logic [2:0]  cnt16;

    int n_cmp = 0;
    int n_mis = 0;
    int n_ferr = 0;
    int n_unf = 0;

    logic [7:0]  sb[$];
    logic [7:0]  exp_last;
    logic        exp_ovf;
    logic [15:0] sb16[$];
    logic [15:0] exp16;

    always #5 clk = ~clk;

    serial_fifo_n dut (
        .clock1M       (clk),
        .reset         (reset),
        .data_in       (data_in),
        .write_in      (write_in),
        .dequeue_in    (dequeue_in),
        .data_out      (data_out),
        .status_out    (status_out),
        .empty_out     (empty_out),
        .count_out     (count_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out),
        .frame_err_out (frame_err_out)
    );

    serial_fifo_n #(
        .DATA_W    (16),
        .DEPTH     (4),
        .BIT_ORDER (serial_fifo_pkg::LSB_FIRST)
    ) dut16 (
        .clock1M       (clk),
        .reset         (reset),
        .data_in       (din16),
        .write_in      (wr16),
        .dequeue_in    (deq16),
        .data_out      (dout16),
        .status_out    (full16),
        .empty_out     (empty16),
        .count_out     (cnt16),
        .overflow_out  (ovf16),
        .underflow_out (unf16),
        .frame_err_out (ferr16)
    );

    always @(negedge clk) begin
        if (frame_err_out === 1'b1) n_ferr++;
        if (underflow_out === 1'b1) n_unf++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] w);
        @(negedge clk);
        write_in = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            data_in = w[i];
            repeat (BC) @(negedge clk);
        end
        write_in = 1'b0;
        data_in  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] w);
        send_frame(w);
        if (sb.size() < 8) sb.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    task automatic pop_chk(input string tag);
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        repeat (3) @(negedge clk);
        if (sb.size() > 0) exp_last = sb.pop_front();
        chk(tag, 32'(data_out), 32'(exp_last));
    endtask

    task automatic send16(input logic [15:0] b);
        @(negedge clk);
        wr16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din16 = b[i];
            repeat (BC) @(negedge clk);
        end
        wr16  = 1'b0;
        din16 = 1'b0;
        repeat (4) @(negedge clk);
        sb16.push_back(b);
    endtask

    task automatic pop16_chk(input string tag);
        @(negedge clk);
        deq16 = 1'b1;
        @(negedge clk);
        deq16 = 1'b0;
        repeat (3) @(negedge clk);
        if (sb16.size() > 0) exp16 = sb16.pop_front();
        chk(tag, 32'(dout16), 32'(exp16));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},  32'(data_out),      32'h0);
        chk({tag, "_full"},  32'(status_out),    32'h0);
        chk({tag, "_empty"}, 32'(empty_out),     32'h1);
        chk({tag, "_count"}, 32'(count_out),     32'h0);
        chk({tag, "_ovf"},   32'(overflow_out),  32'h0);
        chk({tag, "_unf"},   32'(underflow_out), 32'h0);
        chk({tag, "_ferr"},  32'(frame_err_out), 32'h0);
    endtask

    initial begin
        int ferr0;
        int unf0;
        reset = 1'b0;
        data_in = 1'b0; write_in = 1'b0; dequeue_in = 1'b0;
        din16 = 1'b0; wr16 = 1'b0; deq16 = 1'b0;
        exp_last = 8'h00; exp_ovf = 1'b0; exp16 = 16'h0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        chk("rst_data16", 32'(dout16), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Four frames, then four pops in order.
        frame(8'hAA); frame(8'hCC); frame(8'hF0); frame(8'h0F);
        chk("four_count", 32'(count_out), 32'd4);
        chk("four_empty", 32'(empty_out), 32'h0);
        for (int i = 0; i < 4; i++) pop_chk("four_pop");
        chk("four_drained", 32'(empty_out), 32'h1);

        // Nine frames: the ninth is dropped and overflow sticks.
        frame(8'hAA); frame(8'hCC); frame(8'hF0); frame(8'h0F);
        frame(8'h33); frame(8'h55); frame(8'h99);
        chk("seven_full", 32'(status_out), 32'h0);
        frame(8'hFF);
        chk("eight_full", 32'(status_out), 32'h1);
        chk("eight_ovf", 32'(overflow_out), 32'h0);
        frame(8'h00);
        chk("nine_ovf", 32'(overflow_out), 32'(exp_ovf));
        chk("nine_count", 32'(count_out), 32'd8);
        for (int i = 0; i < 8; i++) pop_chk("nine_pop");
        chk("nine_empty", 32'(empty_out), 32'h1);

        // Held dequeue on an empty FIFO: exactly one underflow pulse.
        unf0 = n_unf;
        @(negedge clk);
        dequeue_in = 1'b1;
        repeat (100) @(negedge clk);
        dequeue_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("unf_pulses", 32'(n_unf - unf0), 32'd1);
        chk("unf_data", 32'(data_out), 32'hFF);

        // Aborted frame after five bits, then a good frame.
        ferr0 = n_ferr;
        @(negedge clk);
        write_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = i[0];
            repeat (BC) @(negedge clk);
        end
        write_in = 1'b0;
        data_in  = 1'b0;
        repeat (4) @(negedge clk);
        chk("ferr_pulses", 32'(n_ferr - ferr0), 32'd1);
        chk("ferr_count", 32'(count_out), 32'd0);
        frame(8'h3C);
        chk("ferr_next_count", 32'(count_out), 32'd1);
        pop_chk("ferr_next_pop");
        chk("ovf_sticky", 32'(overflow_out), 32'h1);

        // Fresh start, fill, then push and pop in the same cycle.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete(); exp_last = 8'h00; exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) frame(8'(8'h10 + i));
        chk("fill_full", 32'(status_out), 32'h1);
        // Pop lands on the same edge as the PUSH state (114 edges after write_in rises).
        fork
            send_frame(8'h5A);
            begin
                @(negedge clk);
                repeat (113) @(negedge clk);
                dequeue_in = 1'b1;
                @(negedge clk);
                dequeue_in = 1'b0;
            end
        join
        sb.push_back(8'h5A);
        exp_last = sb.pop_front();
        chk("simul_data", 32'(data_out), 32'(exp_last));
        chk("simul_count", 32'(count_out), 32'd8);
        chk("simul_full", 32'(status_out), 32'h1);
        chk("simul_ovf", 32'(overflow_out), 32'h0);
        for (int i = 0; i < 8; i++) pop_chk("simul_drain");
        chk("simul_empty", 32'(empty_out), 32'h1);

        // Reset mid-frame with stored data, then a clean frame.
        frame(8'h11);
        @(negedge clk);
        write_in = 1'b1;
        data_in  = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        write_in = 1'b0;
        data_in  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete(); exp_last = 8'h00;
        repeat (3) @(negedge clk);
        chk("midrst_count", 32'(count_out), 32'd0);
        frame(8'h81);
        chk("after_rst_count", 32'(count_out), 32'd1);
        pop_chk("after_rst_pop");

        // 16-bit LSB-first instance.
        send16(16'h0001);
        send16(16'hA5C3);
        chk("lsb_count", 32'(cnt16), 32'd2);
        pop16_chk("lsb_pop1");
        chk("lsb_first_word", 32'(dout16), 32'h0001);
        pop16_chk("lsb_pop2");
        chk("lsb_empty", 32'(empty16), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
